// File: rtl/raster_fifo_ctrl.sv
// Flow-control front end for an external ram_fifo: write gating, 2-entry
// prefetch output buffer with one-cycle read latency, occupancy tracking and flush drain.
module raster_fifo_ctrl #(
  parameter int DAT_WID        = 24,
  parameter int FIFO_DEPTH     = 1500,
  parameter int FIFO_DEPTH_WID = 11
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DAT_WID-1:0]        in_dat,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DAT_WID-1:0]        out_dat,
  input  logic                      flush,
  output logic                      fifo_write_enable,
  output logic [DAT_WID-1:0]        fifo_write_dat,
  output logic                      fifo_read_enable,
  input  logic [DAT_WID-1:0]        fifo_read_dat,
  output logic [FIFO_DEPTH_WID-1:0] count,
  output logic                      full,
  output logic                      empty
);

  localparam logic ST_RUN   = 1'b0;
  localparam logic ST_FLUSH = 1'b1;

  localparam logic [FIFO_DEPTH_WID-1:0] DEPTH_C = FIFO_DEPTH_WID'(FIFO_DEPTH);

  logic                      state;
  logic [FIFO_DEPTH_WID-1:0] count_r;
  logic [1:0]                held;
  logic                      pending;
  logic [DAT_WID-1:0]        buf0;
  logic [DAT_WID-1:0]        buf1;

  logic       has_data;
  logic       out_fire;
  logic [2:0] occ;
  logic       wr_slot0;

  always_comb begin
    has_data          = (count_r != '0);
    full              = (count_r == DEPTH_C);
    empty             = !has_data && !pending && (held == 2'd0);
    count             = count_r;
    in_ready          = (state == ST_RUN) && !full;
    fifo_write_enable = in_valid && in_ready;
    fifo_write_dat    = in_dat;
    out_valid         = (state == ST_RUN) && (held != 2'd0);
    out_dat           = buf0;
    out_fire          = out_valid && out_ready;
    // Slots that will be occupied once the in-flight read lands, net of this cycle's pop.
    occ               = {1'b0, held} + {2'b00, pending} - {2'b00, out_fire};
    wr_slot0          = (held == 2'd0) || ((held == 2'd1) && out_fire);
    if (state == ST_RUN) begin
      fifo_read_enable = has_data && (occ < 3'd2);
    end else begin
      fifo_read_enable = has_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_RUN;
      count_r <= '0;
      held    <= 2'd0;
      pending <= 1'b0;
      buf0    <= '0;
      buf1    <= '0;
    end else begin
      count_r <= count_r + FIFO_DEPTH_WID'(fifo_write_enable)
                         - FIFO_DEPTH_WID'(fifo_read_enable);
      pending <= fifo_read_enable;
      if (state == ST_RUN) begin
        if (flush) begin
          // Pending data arriving this cycle is simply not captured.
          state <= ST_FLUSH;
          held  <= 2'd0;
        end else begin
          held <= occ[1:0];
          if (out_fire) begin
            buf0 <= buf1;
          end
          if (pending) begin
            if (wr_slot0) begin
              buf0 <= fifo_read_dat;
            end else begin
              buf1 <= fifo_read_dat;
            end
          end
        end
      end else if (!has_data && !pending) begin
        state <= ST_RUN;
      end
    end
  end

endmodule

// File: tb/tb_raster_fifo_ctrl.sv
// Randomized and directed bench for raster_fifo_ctrl with a queue-based ram_fifo
// model and an in-order scoreboard of accepted samples.
module tb_raster_fifo_ctrl;

  localparam int DW    = 24;
  localparam int DEPTH = 32;
  localparam int CW    = 6;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_dat;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_dat;
  logic          flush;
  logic          fifo_write_enable;
  logic [DW-1:0] fifo_write_dat;
  logic          fifo_read_enable;
  logic [DW-1:0] fifo_read_dat;
  logic [CW-1:0] count;
  logic          full;
  logic          empty;

  raster_fifo_ctrl #(
    .DAT_WID        (DW),
    .FIFO_DEPTH     (DEPTH),
    .FIFO_DEPTH_WID (CW)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .in_dat            (in_dat),
    .out_valid         (out_valid),
    .out_ready         (out_ready),
    .out_dat           (out_dat),
    .flush             (flush),
    .fifo_write_enable (fifo_write_enable),
    .fifo_write_dat    (fifo_write_dat),
    .fifo_read_enable  (fifo_read_enable),
    .fifo_read_dat     (fifo_read_dat),
    .count             (count),
    .full              (full),
    .empty             (empty)
  );

  always #5 clk = ~clk;

  // ram_fifo model: read data valid one cycle after read_enable
  logic [DW-1:0] ram_q[$];
  always @(posedge clk) begin
    if (rst) begin
      ram_q.delete();
      fifo_read_dat <= '0;
    end else begin
      if (fifo_read_enable) begin
        if (ram_q.size() > 0) fifo_read_dat <= ram_q.pop_front();
        else                  fifo_read_dat <= 24'hDEAD00;
      end
      if (fifo_write_enable) ram_q.push_back(fifo_write_dat);
    end
  end

  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  logic [DW-1:0] exp_q[$];
  int unsigned   n_acc, n_out;
  logic          s_out_valid, s_in_ready, s_empty, s_full, s_rd, s_wr, s_fire;
  logic [DW-1:0] s_out_dat;
  logic [CW-1:0] s_count;

  task automatic cyc(input logic iv, input logic [DW-1:0] d, input logic ordy,
                     input logic fl, input logic rs);
    logic [DW-1:0] e;
    @(negedge clk);
    in_valid = iv; in_dat = d; out_ready = ordy; flush = fl; rst = rs;
    #1;
    s_out_valid = out_valid; s_out_dat = out_dat; s_in_ready = in_ready;
    s_empty = empty; s_full = full; s_rd = fifo_read_enable;
    s_wr = fifo_write_enable; s_count = count; s_fire = out_valid && out_ready;
    chk("cnt_le_depth", 32'(count <= CW'(DEPTH)), 1);
    chk("cnt_vs_ram", 32'(count), ram_q.size());
    chk("full_flag", 32'(full), 32'(count == CW'(DEPTH)));
    chk("no_wr_full", 32'(full && fifo_write_enable), 0);
    if (rs) begin
      exp_q.delete();
    end else begin
      if (s_fire) begin
        n_out++;
        if (exp_q.size() == 0) chk("spurious_out", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("out_dat", 32'(out_dat), 32'(e));
        end
      end
      if (iv && in_ready) begin
        exp_q.push_back(d);
        n_acc++;
      end
      if (fl) exp_q.delete();
    end
    @(posedge clk);
  endtask

  task automatic drain(input string tag);
    int unsigned k;
    for (k = 0; k < 500; k++) begin
      cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
      if (s_empty) break;
    end
    chk({tag, "_drain_done"}, 32'(k < 500), 1);
    chk({tag, "_sb_empty"}, exp_q.size(), 0);
  endtask

  task automatic flush_test(input logic wr_in_flush, input int unsigned exp_reads);
    int unsigned nrd, k;
    for (int i = 0; i < 20; i++) cyc(1'b1, DW'(24'h500 + i), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b0, '0, 1'b0, 1'b0, 1'b0);
    chk("fl_pre_cnt", 32'(s_count), 18);
    cyc(wr_in_flush, 24'h77, 1'b0, 1'b1, 1'b0);
    nrd = 0;
    for (k = 0; k < 100; k++) begin
      cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
      if (s_in_ready) break;
      chk("fl_out_valid", 32'(s_out_valid), 0);
      nrd += 32'(s_rd);
    end
    chk("fl_timeout", 32'(k < 100), 1);
    chk("fl_reads", nrd, exp_reads);
    chk("fl_empty", 32'(s_empty), 1);
    cyc(1'b1, 24'h123, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 24'h124, 1'b1, 1'b0, 1'b0);
    n_out = 0;
    for (k = 0; k < 10 && n_out == 0; k++) cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
    chk("fl_first_out", 32'(s_out_dat), 32'h123);
    drain("fl");
  endtask

  initial begin
    int unsigned k, mode, p_iv, p_or;
    in_valid = 0; in_dat = '0; out_ready = 0; flush = 0; rst = 1;
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b0);
    chk("rst_count", 32'(s_count), 0);
    chk("rst_out_valid", 32'(s_out_valid), 0);
    chk("rst_out_dat", 32'(s_out_dat), 0);
    chk("rst_empty", 32'(s_empty), 1);
    chk("rst_in_ready", 32'(s_in_ready), 1);
    chk("rst_rd", 32'(s_rd), 0);

    // five writes with the consumer stalled
    for (int i = 1; i <= 5; i++) cyc(1'b1, DW'(i), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) cyc(1'b0, '0, 1'b0, 1'b0, 1'b0);
    chk("b5_count", 32'(s_count), 3);
    chk("b5_out_valid", 32'(s_out_valid), 1);
    chk("b5_head", 32'(s_out_dat), 1);
    drain("b5");

    // fill to full
    n_acc = 0;
    for (int i = 0; i < DEPTH + 8; i++) cyc(1'b1, DW'(24'h1000 + i), 1'b0, 1'b0, 1'b0);
    chk("full_acc", n_acc, DEPTH + 2);
    chk("full_count", 32'(s_count), DEPTH);
    chk("full_flag_set", 32'(s_full), 1);
    chk("full_in_ready", 32'(s_in_ready), 0);
    chk("full_no_wr", 32'(s_wr), 0);
    drain("full");

    // continuous stream
    n_out = 0;
    for (int i = 0; i < 100; i++) begin
      cyc(1'b1, DW'(24'h2000 + i), 1'b1, 1'b0, 1'b0);
      chk("strm_cnt", 32'(s_count <= 1), 1);
      if (i >= 3) chk("strm_ov", 32'(s_out_valid), 1);
      if (i < 3)  chk("strm_lat", 32'(s_out_valid), 0);
    end
    chk("strm_nout", n_out, 97);
    drain("strm");

    flush_test(1'b0, 18);
    flush_test(1'b1, 19);

    // mid-stream reset
    for (int i = 0; i < 9; i++) cyc(1'b1, DW'(24'h300 + i), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b0, '0, 1'b0, 1'b0, 1'b0);
    chk("mr_pre_cnt", 32'(s_count), 7);
    cyc(1'b1, 24'h999, 1'b1, 1'b1, 1'b1);
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b0);
    chk("mr_count", 32'(s_count), 0);
    chk("mr_out_valid", 32'(s_out_valid), 0);
    chk("mr_run", 32'(s_in_ready), 1);
    cyc(1'b1, 24'hABC, 1'b1, 1'b0, 1'b0);
    n_out = 0;
    for (k = 0; k < 10 && n_out == 0; k++) cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
    chk("mr_roundtrip", 32'(s_out_dat), 32'hABC);
    drain("mr");

    // random stalls, 10k samples
    n_acc = 0; n_out = 0;
    for (k = 0; k < 80000 && (n_acc < 10000 || exp_q.size() != 0); k++) begin
      mode = (k / 500) % 4;
      p_iv = (mode == 1) ? 95 : (mode == 2) ? 15 : (mode == 3) ? 50 : 75;
      p_or = (mode == 1) ? 10 : (mode == 2) ? 90 : (mode == 3) ? 50 : 75;
      cyc((n_acc < 10000) && ($urandom_range(99) < p_iv), DW'($urandom),
          ($urandom_range(99) < p_or), 1'b0, 1'b0);
    end
    chk("rnd_timeout", 32'(k < 80000), 1);
    chk("rnd_nout", n_out, 10000);
    drain("rnd");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
